// File: rtl/fifo_tx_serializer.sv
// Drains words from a FIFO read port and sends each one as a UART-style frame:
// a start bit, the data LSB-first, an optional even-parity bit, then a stop bit.
//
// state  | meaning
// IDLE   | waiting for enable with a non-empty FIFO
// RD     | read strike is high for this one cycle
// LOAD   | fifo_dout is valid; capture the word and its parity
// START  | tx=0 for one bit time
// DATA   | DATA_W data bits, LSB first
// PARITY | even-parity bit (only when PARITY_EN=1)
// STOP   | tx=1 for one bit time, then count the frame
module fifo_tx_serializer #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              read,
  output logic              tx,
  output logic              busy,
  output logic [7:0]        frames_sent
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  state_t state, state_next;

  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [BIT_W-1:0]  bit_cnt, bit_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic              parity_bit, parity_next;
  logic              bit_done;
  logic              tx_next, read_next, busy_next;
  logic [7:0]        frames_next;

  assign bit_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable && !empty) state_next = RD;
      RD:      state_next = LOAD;
      LOAD:    state_next = START;
      START:   if (bit_done) state_next = DATA;
      DATA: begin
        if (bit_done && (bit_cnt == BIT_LAST))
          state_next = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY:  if (bit_done) state_next = STOP;
      STOP:    if (bit_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so every port comes straight off a flop.
  always_comb begin
    baud_next   = baud_cnt;
    bit_next    = bit_cnt;
    shift_next  = shift_reg;
    parity_next = parity_bit;

    if (state_next != state) begin
      baud_next = '0;
      bit_next  = '0;
    end else if (state inside {START, DATA, PARITY, STOP}) begin
      baud_next = bit_done ? '0 : baud_cnt + 1'b1;
      if ((state == DATA) && bit_done) bit_next = bit_cnt + 1'b1;
    end

    if (state == LOAD) begin
      shift_next  = fifo_dout;
      parity_next = ^fifo_dout;
    end else if ((state == DATA) && bit_done) begin
      shift_next = shift_reg >> 1;
    end

    read_next = (state == IDLE) && (state_next == RD);
    busy_next = (state_next != IDLE);

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase

    frames_next = frames_sent;
    if ((state == STOP) && (state_next == IDLE)) frames_next = frames_sent + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      parity_bit  <= 1'b0;
      read        <= 1'b0;
      busy        <= 1'b0;
      tx          <= 1'b1;
      frames_sent <= 8'd0;
    end else begin
      baud_cnt    <= baud_next;
      bit_cnt     <= bit_next;
      shift_reg   <= shift_next;
      parity_bit  <= parity_next;
      read        <= read_next;
      busy        <= busy_next;
      tx          <= tx_next;
      frames_sent <= frames_next;
    end
  end

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Bench for fifo_tx_serializer: a FIFO model feeds the DUT, expected frames are
// queued as words are pushed, and a tx monitor pops and compares each frame.
module tb_fifo_tx_serializer;

  localparam int DATA_W    = 4;
  localparam int CPB       = 4;
  localparam int FRAME_CYC = (2 + DATA_W + 1) * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       empty = 1'b1;
  logic [3:0] fifo_dout = 4'h0;
  logic       read, tx, busy;
  logic [7:0] frames_sent;

  fifo_tx_serializer #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .empty(empty), .fifo_dout(fifo_dout),
    .read(read), .tx(tx), .busy(busy), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  // frame bits as {stop, parity, d3, d2, d1, d0, start}
  typedef struct {
    logic [3:0] word;
    logic [6:0] frame;
  } vec_t;
  vec_t vecs[10];

  int checks = 0;
  int errors = 0;

  logic [3:0] fifo_q[$];
  logic [6:0] exp_q[$];
  int         gap_q[$];

  int         cyc_cnt = 0;
  int         mon_active = 0;
  int         mon_cyc = 0;
  logic [6:0] mon_frame = '0;
  int         mon_glitch = 0;
  int         frames_done = 0;
  int         exp_frames = 0;
  int         post_frame = 0;
  int         last_end = -1;
  int         read_cyc = 0;
  int         start_cyc = 0;
  int         reads_seen = 0;
  logic       prev_read = 1'b0;
  logic [6:0] exp_f;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_word(input vec_t v);
    fifo_q.push_back(v.word);
    exp_q.push_back(v.frame);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      tick();
      n++;
    end
    if (frames_done < target) check("frame_timeout", frames_done, target);
  endtask

  task automatic wait_frame_cyc(input int c, input int budget);
    int n = 0;
    while (!(mon_active != 0 && mon_cyc == c) && n < budget) begin
      tick();
      n++;
    end
    if (!(mon_active != 0 && mon_cyc == c)) check("frame_cyc_timeout", mon_cyc, c);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  // FIFO model and tx frame monitor, all sampled on the falling edge
  always @(negedge clk) begin
    cyc_cnt++;
    if (reset) begin
      mon_active = 0;
      post_frame = 0;
      exp_frames = 0;
      prev_read  = 1'b0;
      last_end   = -1;
    end else begin
      if (read) begin
        reads_seen++;
        read_cyc = cyc_cnt;
        check("read_single_cycle", int'(prev_read), 0);
        check("read_underflow", int'(fifo_q.size() != 0), 1);
        if (fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
      end
      prev_read = read;

      if (post_frame != 0) begin
        check("busy_after_stop", int'(busy), 0);
        check("frames_sent", int'(frames_sent), exp_frames % 256);
        post_frame = 0;
      end

      if (mon_active == 0 && tx == 1'b0) begin
        mon_active = 1;
        mon_cyc    = 0;
        mon_frame  = '0;
        mon_glitch = 0;
        start_cyc  = cyc_cnt;
        check("busy_at_start", int'(busy), 1);
        if (last_end >= 0) gap_q.push_back(cyc_cnt - last_end - 1);
      end

      if (mon_active != 0) begin
        if (mon_cyc % CPB == 0) mon_frame[mon_cyc / CPB] = tx;
        else if (tx != mon_frame[mon_cyc / CPB]) mon_glitch = 1;
        if (mon_cyc == FRAME_CYC - 1) begin
          check("busy_in_stop", int'(busy), 1);
          check("bit_hold", mon_glitch, 0);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", int'(mon_frame), -1);
          end else begin
            exp_f = exp_q.pop_front();
            check("frame_bits", int'(mon_frame), int'(exp_f));
          end
          frames_done++;
          exp_frames++;
          post_frame = 1;
          last_end   = cyc_cnt;
          mon_active = 0;
        end else begin
          mon_cyc++;
        end
      end
    end
    empty = (fifo_q.size() == 0);
  end

  initial begin
    int f0;
    int r0;

    vecs[0] = '{4'hA, 7'b1010100};
    vecs[1] = '{4'h3, 7'b1000110};
    vecs[2] = '{4'h4, 7'b1101000};
    vecs[3] = '{4'h5, 7'b1001010};
    vecs[4] = '{4'h6, 7'b1001100};
    vecs[5] = '{4'h1, 7'b1100010};
    vecs[6] = '{4'h7, 7'b1101110};
    vecs[7] = '{4'hF, 7'b1011110};
    vecs[8] = '{4'h0, 7'b1000000};
    vecs[9] = '{4'h8, 7'b1110000};

    // reset held with a pending word and enable high: nothing may move
    enable = 1'b1;
    tick();
    push_word(vecs[0]);
    repeat (8) begin
      tick();
      check("reset_outputs", int'({tx, read, busy, frames_sent}), int'({1'b1, 1'b0, 1'b0, 8'd0}));
    end
    check("reset_no_read", reads_seen, 0);

    // single word 4'hA after release
    r0 = reads_seen;
    f0 = frames_done;
    reset = 1'b0;
    wait_frames(f0 + 1, 200);
    check("single_reads", reads_seen - r0, 1);
    check("start_latency", start_cyc - read_cyc, 2);
    tick();
    check("single_idle", int'({busy, tx, frames_sent}), int'({1'b0, 1'b1, 8'd1}));

    // back-to-back 3, 4, 5
    do_reset();
    gap_q.delete();
    r0 = reads_seen;
    f0 = frames_done;
    for (int i = 1; i <= 3; i++) push_word(vecs[i]);
    wait_frames(f0 + 3, 400);
    tick();
    check("b2b_reads", reads_seen - r0, 3);
    check("b2b_frames_sent", int'(frames_sent), 3);
    check("b2b_gap_count", gap_q.size(), 2);
    while (gap_q.size() != 0) check("b2b_gap", gap_q.pop_front(), 3);

    // remaining table vectors, one at a time
    for (int i = 5; i < 10; i++) begin
      f0 = frames_done;
      push_word(vecs[i]);
      wait_frames(f0 + 1, 200);
      tick();
      check("table_frames_sent", int'(frames_sent), (3 + i - 4) % 256);
    end

    // empty FIFO with enable high
    repeat (100) begin
      tick();
      check("empty_idle", int'({read, tx, busy}), int'({1'b0, 1'b1, 1'b0}));
    end

    // enable dropped during data bit 2 of 4'h6, word 4'h5 left waiting
    do_reset();
    r0 = reads_seen;
    f0 = frames_done;
    push_word(vecs[4]);
    push_word(vecs[3]);
    wait_frame_cyc(13, 200);
    enable = 1'b0;
    wait_frames(f0 + 1, 200);
    repeat (40) tick();
    check("drop_reads", reads_seen - r0, 1);
    check("drop_idle", int'({busy, tx, frames_sent}), int'({1'b0, 1'b1, 8'd1}));
    enable = 1'b1;
    wait_frames(f0 + 2, 200);
    check("resume_reads", reads_seen - r0, 2);

    // reset at cycle 10 of the second frame: in-flight word 4'h7 is dropped
    do_reset();
    f0 = frames_done;
    push_word(vecs[5]);
    push_word(vecs[6]);
    push_word(vecs[7]);
    wait_frames(f0 + 1, 200);
    wait_frame_cyc(10, 200);
    reset = 1'b1;
    #1;
    check("midreset_async", int'({tx, busy, frames_sent}), int'({1'b1, 1'b0, 8'd0}));
    if (exp_q.size() != 0) exp_f = exp_q.pop_front();
    repeat (3) tick();
    r0 = reads_seen;
    f0 = frames_done;
    reset = 1'b0;
    wait_frames(f0 + 1, 200);
    tick();
    check("midreset_reads", reads_seen - r0, 1);
    check("midreset_frames_sent", int'(frames_sent), 1);

    check("scoreboard_drained", exp_q.size(), 0);
    check("fifo_drained", fifo_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
